// File: rtl/sra_pkg.sv
// Shared width helpers for the SRA arbiter: user-field widths, channel-ID width
// and occupancy-counter width.
package sra_pkg;

    function automatic int muw(input int m_user_bits, input int addr_width);
        return m_user_bits + addr_width;
    endfunction

    function automatic int suw(input int s_user_bits, input int addr_width);
        return s_user_bits + addr_width;
    endfunction

    function automatic int id_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sra_arbiter_if.sv
// Bundle of the N upstream SRA channels plus the single downstream SRA link.
// The slave modport is the arbiter's view, the master modport the environment's.
interface sra_arbiter_if
    import sra_pkg::*;
#(
    parameter int NUM_CH           = 4,
    parameter int DATA_WIDTH_BYTES = 4,
    parameter int ADDR_WIDTH       = 8,
    parameter int M_USER_BITS      = 2,
    parameter int S_USER_BITS      = 2
);
    localparam int DW  = DATA_WIDTH_BYTES * 8;
    localparam int MUW = muw(M_USER_BITS, ADDR_WIDTH);
    localparam int SUW = suw(S_USER_BITS, ADDR_WIDTH);

    logic [NUM_CH-1:0]          up_req_valid;
    logic [NUM_CH-1:0]          up_req_ready;
    logic [NUM_CH-1:0][DW-1:0]  up_req_data;
    logic [NUM_CH-1:0][MUW-1:0] up_req_user;
    logic [NUM_CH-1:0]          up_rsp_valid;
    logic [NUM_CH-1:0]          up_rsp_ready;
    logic [DW-1:0]              up_rsp_data;
    logic [SUW-1:0]             up_rsp_user;

    logic                       dn_req_valid;
    logic                       dn_req_ready;
    logic [DW-1:0]              dn_req_data;
    logic [MUW-1:0]             dn_req_user;
    logic                       dn_rsp_valid;
    logic                       dn_rsp_ready;
    logic [DW-1:0]              dn_rsp_data;
    logic [SUW-1:0]             dn_rsp_user;

    modport slave (
        input  up_req_valid, up_req_data, up_req_user, up_rsp_ready,
        input  dn_req_ready, dn_rsp_valid, dn_rsp_data, dn_rsp_user,
        output up_req_ready, up_rsp_valid, up_rsp_data, up_rsp_user,
        output dn_req_valid, dn_req_data, dn_req_user, dn_rsp_ready
    );

    modport master (
        output up_req_valid, up_req_data, up_req_user, up_rsp_ready,
        output dn_req_ready, dn_rsp_valid, dn_rsp_data, dn_rsp_user,
        input  up_req_ready, up_rsp_valid, up_rsp_data, up_rsp_user,
        input  dn_req_valid, dn_req_data, dn_req_user, dn_rsp_ready
    );

endinterface

// File: rtl/sra_id_fifo.sv
// In-order channel-ID FIFO: remembers which upstream channel owns each
// outstanding downstream request. Head is read combinationally.
module sra_id_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_id,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // A push is refused at full even when a pop lands in the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign full    = (count == CNTW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNTW'(push_ok) - CNTW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_id;
    end

endmodule

// File: rtl/sra_arbiter.sv
// N-to-1 SRA arbiter: round-robin registered request path, combinational
// response steering back to the owning channel via an in-order ID FIFO.
module sra_arbiter
    import sra_pkg::*;
#(
    parameter int NUM_CH           = 4,
    parameter int DATA_WIDTH_BYTES = 4,
    parameter int ADDR_WIDTH       = 8,
    parameter int M_USER_BITS      = 2,
    parameter int S_USER_BITS      = 2,
    parameter int MAX_OUTSTANDING  = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    sra_arbiter_if.slave                        bus,
    output logic [cnt_w(MAX_OUTSTANDING)-1:0]   outstanding,
    output logic                                rsp_orphan
);
    localparam int DW  = DATA_WIDTH_BYTES * 8;
    localparam int MUW = muw(M_USER_BITS, ADDR_WIDTH);
    localparam int CW  = id_w(NUM_CH);

    logic [CW-1:0]  ptr;
    logic [CW-1:0]  grant_id;
    logic [CW-1:0]  next_ptr;
    logic [CW-1:0]  head;
    logic           grant_found;
    logic           load;
    logic           grant;
    logic           fifo_full;
    logic           fifo_empty;
    logic           rsp_pop;
    logic           vld_p1;
    logic [DW-1:0]  req_data_p1;
    logic [MUW-1:0] req_user_p1;

    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(ptr) + k) % NUM_CH;
            if (!grant_found && bus.up_req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = CW'(idx);
            end
        end
    end

    assign load     = !vld_p1 || bus.dn_req_ready;
    assign grant    = load && !fifo_full && grant_found;
    assign next_ptr = (grant_id == CW'(NUM_CH - 1)) ? '0 : grant_id + 1'b1;

    always_comb begin
        bus.up_req_ready = '0;
        if (grant) bus.up_req_ready[grant_id] = 1'b1;
    end

    // Stage p1: single-entry output register towards the downstream slave.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            ptr        <= '0;
            rsp_orphan <= 1'b0;
        end else begin
            rsp_orphan <= bus.dn_rsp_valid && fifo_empty;
            if (grant) begin
                vld_p1 <= 1'b1;
                ptr    <= next_ptr;
            end else if (bus.dn_req_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (grant) begin
            req_data_p1 <= bus.up_req_data[grant_id];
            req_user_p1 <= bus.up_req_user[grant_id];
        end
    end

    assign bus.dn_req_valid = vld_p1;
    assign bus.dn_req_data  = req_data_p1;
    assign bus.dn_req_user  = req_user_p1;

    // With nothing outstanding the response is accepted and dropped.
    always_comb begin
        bus.up_rsp_valid = '0;
        bus.dn_rsp_ready = 1'b1;
        rsp_pop          = 1'b0;
        if (!fifo_empty) begin
            bus.up_rsp_valid[head] = bus.dn_rsp_valid;
            bus.dn_rsp_ready       = bus.up_rsp_ready[head];
            rsp_pop                = bus.dn_rsp_valid && bus.up_rsp_ready[head];
        end
    end

    assign bus.up_rsp_data = bus.dn_rsp_data;
    assign bus.up_rsp_user = bus.dn_rsp_user;

    sra_id_fifo #(
        .WIDTH (CW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (grant),
        .push_id (grant_id),
        .pop     (rsp_pop),
        .head    (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (outstanding)
    );

endmodule

// File: doc/sra_arbiter.md
# sra_arbiter

N-to-1 Simple Register Access arbiter: merges `NUM_CH` upstream SRA masters onto one downstream SRA slave port. Requests are granted round-robin and registered. Responses are routed back to the originating channel through an in-order channel-ID FIFO. The block sits between CPU/debug/DMA register masters and a shared register-bank slave. It generalises the point-to-point SRA link to multiple channels with bounded outstanding transactions.

## Interface
- `NUM_CH`, 4: upstream channel count, ≥2.
- `DATA_WIDTH_BYTES`, 4: data width of requests and responses, in bytes.
- `ADDR_WIDTH`, 8: address width.
- `M_USER_BITS`, 2: request user bits.
- `S_USER_BITS`, 2: response user bits.
- `MAX_OUTSTANDING`, 8: depth of the ID FIFO; must be a power of 2, ≥2.
- Derived: DW = `DATA_WIDTH_BYTES`*8; MUW = `M_USER_BITS`+`ADDR_WIDTH`; SUW = `S_USER_BITS`+`ADDR_WIDTH`; CW = $clog2(`NUM_CH`); OW = $clog2(`MAX_OUTSTANDING`+1).

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `up_req_valid`  in  [NUM_CH]  per-channel request valid.
- `up_req_ready`  out  [NUM_CH]  per-channel request ready.
- `up_req_data`  in  [NUM_CH][DW]  per-channel request data.
- `up_req_user`  in  [NUM_CH][MUW]  per-channel request user, as {m_user, addr}.
- `up_rsp_valid`  out  [NUM_CH]  per-channel response valid.
- `up_rsp_ready`  in  [NUM_CH]  per-channel response ready.
- `up_rsp_data`  out  [DW]  response data, shared across channels.
- `up_rsp_user`  out  [SUW]  response user, shared across channels.
- `dn_req_valid`, `dn_req_ready`, `dn_req_data`, `dn_req_user`  out/in/out/out  1/1/DW/MUW  downstream request.
- `dn_rsp_valid`, `dn_rsp_ready`, `dn_rsp_data`, `dn_rsp_user`  in/out/in/in  1/1/DW/SUW  downstream response.
- `outstanding`  out  OW  number of requests issued downstream and not yet responded.
- `rsp_orphan`  out  1  one-cycle pulse when a response arrives with no outstanding entry.

## Operation
- Contract: the slave returns exactly one response per request, in request order.
- Handshake: a transfer occurs on valid&ready. Once asserted, valid stays high and payload stays stable until the transfer.

Request path:
- Round-robin arbiter over `up_req_valid`. Search starts at channel `ptr`.
- `ptr` resets to 0. After a grant to channel i, `ptr` becomes (i+1) mod `NUM_CH`.
- Output register holds one request. `load` = !`dn_req_valid` | `dn_req_ready`.
- A grant is issued only when `load` & !`fifo_full`. `up_req_ready`[g] = 1 for the granted channel g only; all other bits are 0.
- On an upstream transfer: the register captures data/user, `dn_req_valid` is set, and ID g is pushed into the FIFO in the same cycle.
- Otherwise a downstream transfer clears `dn_req_valid`.

Response path (combinational pass-through):
- head = FIFO head ID.
- When the FIFO is non-empty: `up_rsp_valid`[head] = `dn_rsp_valid`; all other valid bits are 0; `dn_rsp_ready` = `up_rsp_ready`[head].
- Data and user are broadcast to all channels.
- A response transfer pops the FIFO.
- FIFO empty and `dn_rsp_valid`: `dn_rsp_ready`=1, the response is dropped, and `rsp_orphan` pulses for one cycle.
- `outstanding` = FIFO count.
- Full boundary: a push is blocked whenever count==`MAX_OUTSTANDING`, even if a pop occurs in the same cycle.
- Simultaneous push and pop below full: count is unchanged, head advances, and the new ID is written.
- `rst` mid-transaction: in-flight requests and all IDs are discarded. Responses returned after reset are treated as orphans.

## Timing
- Reset values: `dn_req_valid`=0; `ptr`=0; FIFO empty; `outstanding`=0; `rsp_orphan`=0.
- Reset values (combinational outputs, forced by empty FIFO and `dn_req_valid`=0): `up_rsp_valid`=0; `up_req_ready`=0 when no requests are valid.
- Request latency: an upstream transfer in cycle N gives `dn_req_valid`=1 in cycle N+1.
- Request throughput: one per cycle while `dn_req_ready`=1 and the FIFO is not full.
- Response latency: 0 cycles, combinational from `dn_rsp_*` to `up_rsp_*`.
- `outstanding` is registered and reflects the pushes and pops of the previous cycle.
- No combinational path from `up_req_valid` to `dn_req_*`.

## Structure
- Package `sra_pkg`: width helper functions for MUW/SUW and the channel-ID type width.
- Sub-module `sra_id_fifo`: synchronous FIFO, width CW, depth `MAX_OUTSTANDING`.
  - Head read is combinational.
  - Provides full, empty and count outputs.
  - Async active-high reset.
- Arbiter, output register and response steering live in `sra_arbiter`.

## Test plan
- Round-robin fairness: all 4 channels request continuously with `dn_req_ready`=1 → grants run 0,1,2,3,0,… with one request per cycle, and every ID in the downstream order matches the upstream source.
- FIFO full: 8 requests issued with no responses → `outstanding`=8 and `up_req_ready`=0. Return one response → exactly one new grant follows, and `outstanding` returns to 8.
- Response routing: ch2 issues a read, then ch0 issues a read. Slave responds with 0xAAAA then 0x5555 → ch2 receives 0xAAAA and ch0 receives 0x5555. Hold ch2 `up_rsp_ready`=0 for 3 cycles → `dn_rsp_ready` stays 0 for those cycles.
- Downstream backpressure: `dn_req_ready`=0 for 5 cycles while ch1 is valid → one request is captured and stays stable, no second grant occurs, and `ptr` does not advance.
- Orphan response: FIFO empty and `dn_rsp_valid`=1 → `dn_rsp_ready`=1, `rsp_orphan`=1 for one cycle, and all `up_rsp_valid` bits are 0.
- Reset mid-operation: `rst` asserted with 3 requests outstanding → `outstanding`=0 and `dn_req_valid`=0 immediately, and `ptr`=0 after release.
